// File: rtl/maze_move_ctrl.sv
// maze_move_ctrl: paced player movement with wall lookup on maze ROM port B and exit/win detection.
// Define MAZE_MOVE_CTRL_STEP_CNT_EN to add the o_steps accepted-move counter.
module maze_move_ctrl #(
    parameter int unsigned START_BCOL      = 1,
    parameter int unsigned START_BROW      = 1,
    parameter int unsigned EXIT_BCOL       = 38,
    parameter int unsigned EXIT_BROW       = 28,
    parameter int unsigned COLS            = 40,
    parameter int unsigned ROWS            = 30,
    parameter logic [11:0] WALL_COLOR      = 12'h000,
    parameter int unsigned FRAMES_PER_MOVE = 8,
    parameter int unsigned ROM_LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_frame_tick,
    input  logic        i_up,
    input  logic        i_down,
    input  logic        i_left,
    input  logic        i_right,
    input  logic        i_restart,
    output logic        o_rom_en,
    output logic [10:0] o_rom_addr,
    input  logic [15:0] i_rom_data,
    output logic [5:0]  o_player_bcol,
    output logic [5:0]  o_player_brow,
    output logic [5:0]  o_exit_bcol,
    output logic [5:0]  o_exit_brow,
    output logic        o_win,
    output logic        o_busy
`ifdef MAZE_MOVE_CTRL_STEP_CNT_EN
    ,
    output logic [15:0] o_steps
`endif
);
    localparam int PW = $clog2(FRAMES_PER_MOVE + 1);
    localparam int WW = $clog2(ROM_LATENCY + 1);
    localparam logic [PW-1:0] PACE_FULL = PW'(FRAMES_PER_MOVE);
    localparam logic [5:0] S_COL = 6'(START_BCOL);
    localparam logic [5:0] S_ROW = 6'(START_BROW);
    localparam logic [5:0] X_COL = 6'(EXIT_BCOL);
    localparam logic [5:0] X_ROW = 6'(EXIT_BROW);
    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, CHECK, WON} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   pace, pace_n;
    logic [WW-1:0]   wcnt, wcnt_n;
    logic [5:0]      tcol, trow, tcol_n, trow_n, col_n, row_n, dcol, drow;
    logic [10:0]     addr_n;
    logic            win_n, any_dir, in_bounds, wall, unused_rom_hi;

    assign o_exit_bcol   = X_COL;
    assign o_exit_brow   = X_ROW;
    assign unused_rom_hi = ^i_rom_data[15:12];
    assign any_dir       = i_up | i_down | i_left | i_right;
    assign wall          = i_rom_data[11:0] == WALL_COLOR;
    // Priority up > down > left > right also settles opposing buttons.
    assign dcol = (i_up | i_down) ? o_player_bcol :
                  i_left ? o_player_bcol - 6'd1 : o_player_bcol + 6'd1;
    assign drow = i_up ? o_player_brow - 6'd1 : i_down ? o_player_brow + 6'd1 : o_player_brow;
    assign in_bounds = i_up ? o_player_brow != 6'd0 :
                       i_down ? o_player_brow != LAST_ROW :
                       i_left ? o_player_bcol != 6'd0 : o_player_bcol != LAST_COL;

    always_comb begin
        state_n = state;
        pace_n  = (i_frame_tick && pace != PACE_FULL) ? pace + PW'(1) : pace;
        wcnt_n  = wcnt;
        tcol_n  = tcol;
        trow_n  = trow;
        col_n   = o_player_bcol;
        row_n   = o_player_brow;
        addr_n  = o_rom_addr;
        win_n   = o_win;
        case (state)
            IDLE: if (pace == PACE_FULL && any_dir) begin
                pace_n = '0;
                if (in_bounds) begin
                    tcol_n  = dcol;
                    trow_n  = drow;
                    addr_n  = {dcol, 5'd0} + {5'd0, drow};
                    state_n = READ;
                end
            end
            READ: begin
                wcnt_n  = '0;
                state_n = WAIT;
            end
            WAIT: begin
                wcnt_n  = wcnt + WW'(1);
                state_n = (wcnt == WW'(ROM_LATENCY - 1)) ? CHECK : WAIT;
            end
            CHECK: begin
                col_n   = wall ? o_player_bcol : tcol;
                row_n   = wall ? o_player_brow : trow;
                win_n   = col_n == X_COL && row_n == X_ROW;
                state_n = win_n ? WON : IDLE;
            end
            default: ;
        endcase
        // Restart abandons any attempt in flight and outranks a same-cycle CHECK.
        if (i_restart) begin
            state_n = IDLE;
            pace_n  = PACE_FULL;
            col_n   = S_COL;
            row_n   = S_ROW;
            win_n   = 1'b0;
            addr_n  = o_rom_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pace          <= PACE_FULL;
            wcnt          <= '0;
            tcol          <= '0;
            trow          <= '0;
            o_player_bcol <= S_COL;
            o_player_brow <= S_ROW;
            o_rom_en      <= 1'b0;
            o_rom_addr    <= '0;
            o_win         <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            state         <= state_n;
            pace          <= pace_n;
            wcnt          <= wcnt_n;
            tcol          <= tcol_n;
            trow          <= trow_n;
            o_player_bcol <= col_n;
            o_player_brow <= row_n;
            o_rom_en      <= state_n == READ;
            o_rom_addr    <= addr_n;
            o_win         <= win_n;
            o_busy        <= state_n inside {READ, WAIT, CHECK};
        end
    end

`ifdef MAZE_MOVE_CTRL_STEP_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_steps <= '0;
        else if (i_restart)
            o_steps <= '0;
        else if (state == CHECK && !wall && o_steps != 16'hFFFF)
            o_steps <= o_steps + 16'd1;
    end
`endif

endmodule

// File: tb/tb_maze_move_ctrl.sv
// tb_maze_move_ctrl: directed and random stimulus for maze_move_ctrl against an attempt-level model.
module tb_maze_move_ctrl;
    localparam int L = 1;
    localparam int F = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_frame_tick = 0, i_up = 0, i_down = 0, i_left = 0, i_right = 0, i_restart = 0;
    logic        o_rom_en, o_win, o_busy;
    logic [10:0] o_rom_addr;
    logic [15:0] i_rom_data = '0;
    logic [5:0]  o_player_bcol, o_player_brow, o_exit_bcol, o_exit_brow;
    logic [15:0] o_steps;
    logic [3:0]  btn = '0;

    bit wall [64][32];
    int n_tests = 0, n_fail = 0;
    int m_col = 1, m_row = 1, m_tc = 0, m_tr = 0, m_left = 0, m_pace = F, m_addr = 0, m_steps = 0;
    int np, dx, dy;
    bit m_win = 0;

    maze_move_ctrl dut (
        .clk(clk), .rst(rst), .i_frame_tick(i_frame_tick),
        .i_up(i_up), .i_down(i_down), .i_left(i_left), .i_right(i_right), .i_restart(i_restart),
        .o_rom_en(o_rom_en), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
        .o_player_bcol(o_player_bcol), .o_player_brow(o_player_brow),
        .o_exit_bcol(o_exit_bcol), .o_exit_brow(o_exit_brow),
        .o_win(o_win), .o_busy(o_busy)
`ifdef MAZE_MOVE_CTRL_STEP_CNT_EN
        , .o_steps(o_steps)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic drv(input bit u, input bit d, input bit l, input bit r, input bit tk, input bit rs);
        i_up = u; i_down = d; i_left = l; i_right = r; i_frame_tick = tk; i_restart = rs;
        @(posedge clk);
        #2;
    endtask

    task automatic set_walls(input bit rnd);
        for (int c = 0; c < 64; c++)
            for (int r = 0; r < 32; r++)
                wall[c][r] = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
    endtask

    // Port-B ROM: data valid one cycle after the enable is sampled, held until the next read.
    always @(posedge clk)
        if (o_rom_en)
            i_rom_data <= wall[o_rom_addr[10:5]][o_rom_addr[4:0]] ? {4'($urandom), 12'h000}
                                                                  : {4'($urandom), 12'($urandom_range(1, 4095))};

    // Reference: an attempt is a countdown of L+2 cycles, resolved against the wall map at its end.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_col = 1; m_row = 1; m_win = 0; m_pace = F; m_left = 0; m_addr = 0; m_steps = 0;
        end else if (i_restart) begin
            m_col = 1; m_row = 1; m_win = 0; m_pace = F; m_left = 0; m_steps = 0;
        end else begin
            np = (i_frame_tick && m_pace < F) ? m_pace + 1 : m_pace;
            if (m_left == 1) begin
                if (!wall[m_tc][m_tr]) begin
                    m_col = m_tc; m_row = m_tr;
                    if (m_steps < 65535) m_steps++;
                end
                m_win = (m_col == 38 && m_row == 28);
                m_left = 0;
            end else if (m_left > 1) begin
                m_left--;
            end else if (!m_win && m_pace == F && (i_up || i_down || i_left || i_right)) begin
                np = 0;
                dy = i_up ? -1 : i_down ? 1 : 0;
                dx = (i_up || i_down) ? 0 : i_left ? -1 : 1;
                if (m_col + dx >= 0 && m_col + dx < 40 && m_row + dy >= 0 && m_row + dy < 30) begin
                    m_tc = m_col + dx; m_tr = m_row + dy;
                    m_addr = m_tc * 32 + m_tr;
                    m_left = L + 2;
                end
            end
            m_pace = np;
        end
    end

    always @(negedge clk) begin
        chk("player_col", o_player_bcol, m_col);
        chk("player_row", o_player_brow, m_row);
        chk("win", o_win, m_win);
        chk("rom_en", o_rom_en, m_left == L + 2);
        chk("busy", o_busy, m_left != 0);
        chk("rom_addr", o_rom_addr, m_addr);
        chk("exit_col", o_exit_bcol, 38);
        chk("exit_row", o_exit_brow, 28);
`ifdef MAZE_MOVE_CTRL_STEP_CNT_EN
        chk("steps", o_steps, m_steps);
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_walls(0);
        wall[1][0] = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 0;
        repeat (20) drv(0, 0, 0, 0, 1, 0);
        repeat (12) drv(1, 0, 0, 0, 1, 0);
        repeat (30) drv(0, 0, 1, 0, 1, 0);
        repeat (12) drv(1, 1, 0, 0, 1, 0);
        drv(0, 0, 0, 0, 0, 1);
        repeat (3) drv(0, 0, 0, 0, 0, 0);
        repeat (24) drv(0, 0, 0, 1, 1, 0);
        // Restart landing on the WAIT cycle of an attempt.
        drv(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 50 && m_left != L + 1; i++) drv(0, 0, 0, 1, 1, 0);
        chk("reach_wait", m_left, L + 1);
        drv(0, 0, 0, 1, 1, 1);
        repeat (6) drv(0, 0, 0, 0, 1, 0);
        // Async reset in the middle of an attempt.
        for (int i = 0; i < 50 && m_left != L + 2; i++) drv(0, 1, 0, 0, 1, 0);
        chk("reach_read", m_left, L + 2);
        rst = 1;
        repeat (2) drv(0, 0, 0, 0, 0, 0);
        rst = 0;
        set_walls(1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) btn = 4'($urandom);
            drv(btn[3], btn[2], btn[1], btn[0], $urandom_range(0, 1) == 1, $urandom_range(0, 299) == 0);
        end
        drv(0, 0, 0, 0, 0, 1);
        set_walls(0);
        for (int i = 0; i < 3000 && !m_win; i++) drv(0, m_col == 38, 0, m_col != 38, 1, 0);
        chk("win_reached", o_win, 1);
        for (int i = 0; i < 60; i++) drv(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1, 0);
        drv(0, 0, 0, 0, 1, 1);
        repeat (4) drv(0, 0, 0, 0, 1, 0);
        chk("restart_col", o_player_bcol, 1);
        chk("restart_win", o_win, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/maze_move_ctrl.md
Name: maze_move_ctrl

Overview:
- Player-movement controller for the maze game.
- Samples direction buttons, paced by frame ticks, and reads the target maze block through the maze ROM's second read port to check for a wall.
- Updates the player block position (feeding the frame renderer), detects arrival at the exit and latches a win flag.
- Sole owner of maze ROM port B; sequences every read on it.

Parameters:
- START_BCOL, 1, player start column (blocks)
- START_BROW, 1, player start row (blocks)
- EXIT_BCOL, 38, exit column
- EXIT_BROW, 28, exit row
- COLS, 40, maze width in blocks
- ROWS, 30, maze height in blocks
- WALL_COLOR, 12'h000, ROM data[11:0] value that marks a wall block
- FRAMES_PER_MOVE, 8, minimum frame ticks between accepted move attempts (>=1)
- ROM_LATENCY, 1, cycles from the en-sampling edge until port-B data is valid (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- i_frame_tick  in  1  one-cycle pulse, once per video frame
- i_up  in  1  direction held, level, already debounced
- i_down  in  1  direction held
- i_left  in  1  direction held
- i_right  in  1  direction held
- i_restart  in  1  one-cycle pulse: return player to start, clear win
- o_rom_en  out  1  maze ROM port-B enable
- o_rom_addr  out  11  maze ROM port-B address = bcol*32 + brow
- i_rom_data  in  16  maze ROM port-B data
- o_player_bcol  out  6  player column
- o_player_brow  out  6  player row
- o_exit_bcol  out  6  constant EXIT_BCOL
- o_exit_brow  out  6  constant EXIT_BROW
- o_win  out  1  player on exit block
- o_busy  out  1  move attempt in progress (state != IDLE/WON)

Behaviour:
- Clock clk; reset rst, asynchronous, active-high.
- Reset values:
  - player = (START_BCOL, START_BROW)
  - o_rom_en=0, o_rom_addr=0, o_win=0, o_busy=0
  - pace counter = FRAMES_PER_MOVE (so the first press acts immediately)
  - state IDLE
- All outputs are registered.
- Pace counter: +1 on each i_frame_tick, saturates at FRAMES_PER_MOVE; cleared to 0 when an attempt is launched.
- FSM states: IDLE, READ, WAIT, CHECK, WON.
- IDLE:
  - If pace==FRAMES_PER_MOVE and any direction is held, choose one direction by priority up>down>left>right (opposing held buttons resolve by priority).
  - Target: up = row-1, down = row+1, left = col-1, right = col+1.
  - If the target is outside 0..COLS-1 / 0..ROWS-1, clear pace and stay in IDLE; no ROM access.
  - Otherwise latch the target, drive o_rom_addr = tcol*32+trow and go to READ.
- READ: o_rom_en=1 for exactly this one cycle; o_rom_addr held; go to WAIT.
- WAIT: hold for ROM_LATENCY-1 further cycles (0 extra when latency is 1); then go to CHECK.
- CHECK:
  - Sample i_rom_data[11:0]. If it equals WALL_COLOR, the position is unchanged.
  - Otherwise the player takes the target position.
  - If the new position == exit, set o_win=1 and go to WON; else go to IDLE.
  - Accepted move: IDLE->IDLE takes 4 cycles at ROM_LATENCY=1.
- WON: buttons ignored, no ROM reads.
- i_restart:
  - In any state, next cycle: player=start, o_win=0, o_rom_en=0, pace=FRAMES_PER_MOVE, state IDLE.
  - An in-flight attempt is abandoned and its data ignored.
  - Restart takes precedence over a same-cycle CHECK update.
- A frame tick in any state still advances pace (saturating).
- o_rom_en is never asserted outside READ; port B is otherwise idle.
- Async reset mid-attempt returns everything to reset values immediately.

Optional Feature:
- Macro: MAZE_MOVE_CTRL_STEP_CNT_EN.
- When defined:
  - Adds output o_steps [15:0]: count of accepted moves (wall bumps and out-of-bounds attempts excluded).
  - Saturates at 16'hFFFF.
  - Cleared by reset and by i_restart; frozen in WON.
- When undefined: the port and the counter do not exist.

Test Plan:
- Reset, no buttons, 20 ticks -> player (1,1), o_rom_en never high, o_win=0, o_exit=(38,28).
- Hold i_right, ROM returns 12'h0F0 -> one o_rom_en pulse with addr=2*32+1=65, player (2,1) 4 cycles after launch; next attempt only after 8 frame ticks.
- Hold i_up at (1,1), ROM returns 12'h000 (wall) -> addr=1*32+0=32 read, player stays (1,1), o_steps unchanged.
- Player at (0,5), hold i_left -> no ROM read, position unchanged; hold i_up+i_down -> up chosen (addr 4).
- Player at (37,28), i_right, ROM non-wall -> player (38,28), o_win=1, further buttons cause no reads; i_restart -> (1,1), o_win=0, o_steps=0.
- i_restart pulsed during WAIT -> o_rom_en low, player start, state IDLE, late ROM data ignored.
